// File: rtl/instr_fetch_stage_if.sv
// Bus bundle between the IF stage, the combinational instruction ROM and the
// IF/ID register consumer (decode).
interface instr_fetch_stage_if #(
  parameter int ROM_ADDR_BITS = 10,
  parameter int DATA_BITS     = 32
);
  logic [ROM_ADDR_BITS-1:0] rom_addr;
  logic                     rom_sel;
  logic [DATA_BITS-1:0]     rom_data;
  logic                     ifid_valid;
  logic [DATA_BITS-1:0]     ifid_instr;
  logic [31:0]              ifid_pc;
  logic [31:0]              ifid_pc4;

  modport master (
    output rom_addr, rom_sel,
    input  rom_data,
    output ifid_valid, ifid_instr, ifid_pc, ifid_pc4
  );

  modport slave (
    input  rom_addr, rom_sel,
    output rom_data,
    input  ifid_valid, ifid_instr, ifid_pc, ifid_pc4
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, ROM addressing and the
// IF/ID pipeline register, with stall/flush/redirect/halt control.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          ROM_ADDR_BITS = 10,
  parameter int          DATA_BITS     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  instr_fetch_stage_if.master        bus,
  input  logic                       i_stall,
  input  logic                       i_flush,
  input  logic                       i_redirect,
  input  logic [31:0]                i_redirect_pc,
  input  logic                       i_halt,
  output logic [31:0]                o_pc,
  output logic                       o_halted
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & PC_ALIGN_MASK;

  state_t                r_state;
  state_t                w_nextState;
  logic [31:0]           r_pc;
  logic [31:0]           w_nextPc;
  logic [31:0]           w_pcPlus4;
  logic [31:0]           w_redirectPc;
  logic                  w_bubble;
  logic                  w_capture;

  logic                  r_ifidValid;
  logic [DATA_BITS-1:0]  r_ifidInstr;
  logic [31:0]           r_ifidPc;
  logic [31:0]           r_ifidPc4;
  logic                  w_nextIfidValid;
  logic [DATA_BITS-1:0]  w_nextIfidInstr;
  logic [31:0]           w_nextIfidPc;
  logic [31:0]           w_nextIfidPc4;

  assign w_pcPlus4    = r_pc + 32'd4;
  assign w_redirectPc = i_redirect_pc & PC_ALIGN_MASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Priority inside RUN: halt > redirect > flush > stall > normal fetch.
  always_comb begin
    w_nextState = r_state;
    w_nextPc    = r_pc;
    w_bubble    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_nextState = ST_RUN;
        w_bubble    = 1'b1;
      end
      ST_RUN: begin
        if (i_halt) begin
          w_nextState = ST_HALT;
          w_bubble    = 1'b1;
        end else if (i_redirect) begin
          w_nextPc = w_redirectPc;
          w_bubble = 1'b1;
        end else if (i_flush) begin
          w_bubble = 1'b1;
          if (!i_stall) begin
            w_nextPc = w_pcPlus4;
          end
        end else if (!i_stall) begin
          w_nextPc  = w_pcPlus4;
          w_capture = 1'b1;
        end
      end
      ST_HALT: begin
        w_nextState = ST_HALT;
      end
      default: begin
        w_nextState = ST_BOOT;
        w_bubble    = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_nextIfidValid = r_ifidValid;
    w_nextIfidInstr = r_ifidInstr;
    w_nextIfidPc    = r_ifidPc;
    w_nextIfidPc4   = r_ifidPc4;
    if (w_bubble) begin
      w_nextIfidValid = 1'b0;
      w_nextIfidInstr = '0;
      w_nextIfidPc    = '0;
      w_nextIfidPc4   = '0;
    end else if (w_capture) begin
      w_nextIfidValid = 1'b1;
      w_nextIfidInstr = bus.rom_data;
      w_nextIfidPc    = r_pc;
      w_nextIfidPc4   = w_pcPlus4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC_ALIGNED;
      r_ifidValid <= 1'b0;
      r_ifidInstr <= '0;
      r_ifidPc    <= '0;
      r_ifidPc4   <= '0;
    end else begin
      r_pc        <= w_nextPc;
      r_ifidValid <= w_nextIfidValid;
      r_ifidInstr <= w_nextIfidInstr;
      r_ifidPc    <= w_nextIfidPc;
      r_ifidPc4   <= w_nextIfidPc4;
    end
  end

  // PCs beyond the ROM depth simply wrap through address truncation.
  assign bus.rom_addr   = r_pc[ROM_ADDR_BITS+1:2];
  assign bus.rom_sel    = (r_state == ST_RUN);
  assign bus.ifid_valid = r_ifidValid;
  assign bus.ifid_instr = r_ifidValid ? r_ifidInstr : '0;
  assign bus.ifid_pc    = r_ifidPc;
  assign bus.ifid_pc4   = r_ifidPc4;
  assign o_pc           = r_pc;
  assign o_halted       = (r_state == ST_HALT);

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: directed steps push hand-computed
// expectations, a monitor pops and compares after each edge or async reset.
module tb_instr_fetch_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ifidPc;
    logic [31:0] ifidPc4;
    logic        halted;
    logic        romSel;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        halt;
  logic [31:0] pc;
  logic        halted;

  logic [31:0] rom [0:1023];
  exp_t        expQ[$];
  string       nameQ[$];
  int          checks;
  int          fails;
  event        asyncEv;

  instr_fetch_stage_if #(.ROM_ADDR_BITS(10), .DATA_BITS(32)) bus ();

  instr_fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .ROM_ADDR_BITS(10),
    .DATA_BITS(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .i_stall(stall),
    .i_flush(flush),
    .i_redirect(redirect),
    .i_redirect_pc(redirectPc),
    .i_halt(halt),
    .o_pc(pc),
    .o_halted(halted)
  );

  assign bus.rom_data = rom[bus.rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic pushExpected(input logic [31:0] ePc, input logic eValid, input logic [31:0] eInstr,
                              input logic [31:0] eIpc, input logic [31:0] eIpc4, input logic eHalt,
                              input logic eRomSel, input string name);
    exp_t e;
    e.pc = ePc; e.valid = eValid; e.instr = eInstr; e.ifidPc = eIpc;
    e.ifidPc4 = eIpc4; e.halted = eHalt; e.romSel = eRomSel;
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  // Drives one cycle's inputs, records what must be visible after the next edge.
  task automatic applyStimulus(input logic st, input logic fl, input logic rd, input logic [31:0] rpc,
                               input logic ht, input logic [31:0] ePc, input logic eValid,
                               input logic [31:0] eInstr, input logic [31:0] eIpc,
                               input logic [31:0] eIpc4, input logic eHalt, input logic eRomSel,
                               input string name);
    stall = st; flush = fl; redirect = rd; redirectPc = rpc; halt = ht;
    pushExpected(ePc, eValid, eInstr, eIpc, eIpc4, eHalt, eRomSel, name);
    @(negedge clk);
  endtask

  // Monitor: pops one expectation per edge (or async-reset event) when one is pending.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk or asyncEv);
      #1;
      if (expQ.size() > 0) begin
        e  = expQ.pop_front();
        nm = nameQ.pop_front();
        checkOutput({nm, ".pc"},       pc,                    e.pc);
        checkOutput({nm, ".valid"},    {31'd0, bus.ifid_valid}, {31'd0, e.valid});
        checkOutput({nm, ".instr"},    bus.ifid_instr,        e.instr);
        checkOutput({nm, ".ifidPc"},   bus.ifid_pc,           e.ifidPc);
        checkOutput({nm, ".ifidPc4"},  bus.ifid_pc4,          e.ifidPc4);
        checkOutput({nm, ".halted"},   {31'd0, halted},       {31'd0, e.halted});
        checkOutput({nm, ".romSel"},   {31'd0, bus.rom_sel},  {31'd0, e.romSel});
      end
    end
  end

  initial begin
    checks = 0;
    fails  = 0;
    for (int i = 0; i < 1024; i++) rom[i] = 32'hC0DE_0000 + i;
    rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirectPc = '0; halt = 1'b0;

    #2;
    pushExpected(32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, "reset");
    ->asyncEv;
    @(negedge clk);
    rst_n = 1'b1;

    //            st fl rd rpc           ht  pc            v  instr         ifidPc        ifidPc4       h  rs
    applyStimulus(0, 0, 0, 32'h0,        0,  32'h0,        0, 32'h0,        32'h0,        32'h0,        0, 1, "boot");
    applyStimulus(0, 0, 0, 32'h0,        0,  32'h4,        1, 32'h11,       32'h0,        32'h4,        0, 1, "fetch0");
    applyStimulus(0, 0, 0, 32'h0,        0,  32'h8,        1, 32'h22,       32'h4,        32'h8,        0, 1, "fetch4");
    applyStimulus(0, 0, 0, 32'h0,        0,  32'hC,        1, 32'h33,       32'h8,        32'hC,        0, 1, "fetch8");
    applyStimulus(0, 0, 0, 32'h0,        0,  32'h10,       1, 32'h44,       32'hC,        32'h10,       0, 1, "fetchC");
    applyStimulus(0, 0, 1, 32'h4,        0,  32'h4,        0, 32'h0,        32'h0,        32'h0,        0, 1, "redir4");
    applyStimulus(0, 0, 0, 32'h0,        0,  32'h8,        1, 32'h22,       32'h4,        32'h8,        0, 1, "refetch4");
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 0, 0, 32'h0,      0,  32'h8,        1, 32'h22,       32'h4,        32'h8,        0, 1, "stall");
    applyStimulus(0, 0, 0, 32'h0,        0,  32'hC,        1, 32'h33,       32'h8,        32'hC,        0, 1, "unstall");
    applyStimulus(1, 1, 0, 32'h0,        0,  32'hC,        0, 32'h0,        32'h0,        32'h0,        0, 1, "flushStall");
    applyStimulus(1, 1, 1, 32'h43,       0,  32'h40,       0, 32'h0,        32'h0,        32'h0,        0, 1, "redir43");
    applyStimulus(0, 0, 0, 32'h0,        0,  32'h44,       1, 32'hC0DE0010, 32'h40,       32'h44,       0, 1, "fetch40");
    applyStimulus(0, 1, 0, 32'h0,        0,  32'h48,       0, 32'h0,        32'h0,        32'h0,        0, 1, "flush");
    applyStimulus(0, 0, 0, 32'h0,        0,  32'h4C,       1, 32'hC0DE0012, 32'h48,       32'h4C,       0, 1, "fetch48");
    applyStimulus(0, 0, 1, 32'hFFFFFFFF, 0,  32'hFFFFFFFC, 0, 32'h0,        32'h0,        32'h0,        0, 1, "redirTop");
    applyStimulus(0, 0, 0, 32'h0,        0,  32'h0,        1, 32'hC0DE03FF, 32'hFFFFFFFC, 32'h0,        0, 1, "wrap");
    applyStimulus(0, 0, 1, 32'h1C,       0,  32'h1C,       0, 32'h0,        32'h0,        32'h0,        0, 1, "redir1C");
    applyStimulus(0, 0, 0, 32'h0,        0,  32'h20,       1, 32'hC0DE0007, 32'h1C,       32'h20,       0, 1, "fetch1C");

    #2;
    rst_n = 1'b0;
    pushExpected(32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, "asyncReset");
    ->asyncEv;
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(0, 0, 0, 32'h0,        0,  32'h0,        0, 32'h0,        32'h0,        32'h0,        0, 1, "reboot");
    applyStimulus(0, 0, 0, 32'h0,        0,  32'h4,        1, 32'h11,       32'h0,        32'h4,        0, 1, "restart0");
    applyStimulus(0, 0, 0, 32'h0,        0,  32'h8,        1, 32'h22,       32'h4,        32'h8,        0, 1, "restart4");
    applyStimulus(0, 0, 0, 32'h0,        0,  32'hC,        1, 32'h33,       32'h8,        32'hC,        0, 1, "restart8");
    applyStimulus(0, 0, 0, 32'h0,        0,  32'h10,       1, 32'h44,       32'hC,        32'h10,       0, 1, "restartC");
    applyStimulus(0, 0, 1, 32'h80,       1,  32'h10,       0, 32'h0,        32'h0,        32'h0,        1, 0, "haltRedir");
    applyStimulus(0, 0, 1, 32'h80,       0,  32'h10,       0, 32'h0,        32'h0,        32'h0,        1, 0, "haltIgnRedir");
    applyStimulus(0, 1, 0, 32'h0,        0,  32'h10,       0, 32'h0,        32'h0,        32'h0,        1, 0, "haltIgnFlush");
    applyStimulus(0, 0, 0, 32'h0,        0,  32'h10,       0, 32'h0,        32'h0,        32'h0,        1, 0, "haltHold");

    @(negedge clk);
    checkOutput("queueDrained", expQ.size(), 32'd0);
    $display("[TB] %0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
